// File: rtl/alu_pipe_if.sv
// Handshake and data bundle for alu_pipe: operand/opcode request side and
// registered result/flags response side.
interface alu_pipe_if #(
  parameter int WIDTH = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       Op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] R;
  logic             Z;
  logic             C;
  logic             N;
  logic             V;

  // Producer/consumer side: drives operands and accepts results.
  modport master (
    output in_valid, A, B, Op, out_ready,
    input  in_ready, out_valid, R, Z, C, N, V
  );

  // ALU side.
  modport slave (
    input  in_valid, A, B, Op, out_ready,
    output in_ready, out_valid, R, Z, C, N, V
  );

endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU operand conditioner and adder with accumulator,
// carry flag and valid/ready flow control on both sides.
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  alu_pipe_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_TRANSFER = 3'b000,
    OP_NEGATE   = 3'b001,
    OP_ADD      = 3'b010,
    OP_INC      = 3'b011,
    OP_SUB      = 3'b100,
    OP_ACC_ADD  = 3'b101,
    OP_ACC_SUB  = 3'b110,
    OP_ADC      = 3'b111
  } op_e;

  localparam int MSB = WIDTH - 1;

  // Stage 1: captured request.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;

  // Stage 2: registered result and architectural state.
  logic             out_valid;
  logic [WIDTH-1:0] r_q;
  logic             z_q;
  logic             c_q;
  logic             n_q;
  logic             v_q;
  logic [WIDTH-1:0] acc;
  logic             cf;

  // Flow control.
  logic adv;
  logic s1_load;
  logic s2_load;

  // Operand conditioning and adder.
  logic [WIDTH-1:0] a_mod;
  logic [WIDTH-1:0] b_mod;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r_next;
  logic             c_next;
  logic             z_next;
  logic             n_next;
  logic             v_next;

  // ---------------------------------------------------------------------------
  // Handshake: stage 2 advances when empty or being drained; stage 1 can take
  // a new request whenever its content moves on in the same cycle.
  // ---------------------------------------------------------------------------
  assign adv          = !out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || adv;
  assign s1_load      = bus.in_valid && bus.in_ready;
  assign s2_load      = s1_valid && adv;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // NOTE: operand registers are qualified by s1_valid, so they carry no reset;
  // only control and architecturally visible state is cleared.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_a  <= bus.A;
      s1_b  <= bus.B;
      s1_op <= op_e'(bus.Op);
    end
  end

  // ---------------------------------------------------------------------------
  // Operand selection. ACC/CF are read live here, so a dependent op directly
  // behind its producer sees the value written at the producer's capture edge.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    a_mod = '0;
    b_mod = s1_a;
    cin   = 1'b0;
    case (s1_op)
      OP_TRANSFER: begin
        a_mod = '0;
        b_mod = s1_a;
        cin   = 1'b0;
      end
      OP_NEGATE: begin
        a_mod = '0;
        b_mod = ~s1_a;
        cin   = 1'b1;
      end
      OP_ADD: begin
        a_mod = s1_a;
        b_mod = s1_b;
        cin   = 1'b0;
      end
      OP_INC: begin
        a_mod = s1_a;
        b_mod = '0;
        cin   = 1'b1;
      end
      OP_SUB: begin
        a_mod = s1_a;
        b_mod = ~s1_b;
        cin   = 1'b1;
      end
      OP_ACC_ADD: begin
        a_mod = acc;
        b_mod = s1_a;
        cin   = 1'b0;
      end
      OP_ACC_SUB: begin
        a_mod = acc;
        b_mod = ~s1_a;
        cin   = 1'b1;
      end
      OP_ADC: begin
        a_mod = s1_a;
        b_mod = s1_b;
        cin   = cf;
      end
      default: begin
        a_mod = '0;
        b_mod = s1_a;
        cin   = 1'b0;
      end
    endcase
  end

  assign sum    = {1'b0, a_mod} + {1'b0, b_mod} + {{WIDTH{1'b0}}, cin};
  assign r_next = sum[MSB:0];
  assign c_next = sum[WIDTH];
  assign z_next = (r_next == '0);
  assign n_next = r_next[MSB];
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign v_next = (a_mod[MSB] == b_mod[MSB]) && (r_next[MSB] != a_mod[MSB]);

  // ---------------------------------------------------------------------------
  // Stage 2: result register. ACC/CF advance only on capture, so a stalled op
  // cannot disturb them until it actually completes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      r_q       <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      acc       <= '0;
      cf        <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      r_q       <= r_next;
      z_q       <= z_next;
      c_q       <= c_next;
      n_q       <= n_next;
      v_q       <= v_next;
      acc       <= r_next;
      cf        <= c_next;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.R         = r_q;
  assign bus.Z         = z_q;
  assign bus.C         = c_q;
  assign bus.N         = n_q;
  assign bus.V         = v_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: arithmetic reference model with a result
// queue checked every cycle, plus directed vectors with literal expectations.
module tb_alu_pipe;

  localparam int W    = 4;
  localparam int MOD  = 1 << W;
  localparam int MASK = MOD - 1;
  localparam int HALF = MOD / 2;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         n;
    logic         v;
  } exp_t;

  logic clk;
  logic reset;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t exp_q[$];
  int   m_acc;
  int   m_cf;
  int   seen_r[$];
  int   seen_c[$];
  int   seen_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= HALF) ? x - MOD : x;
  endfunction

  // Reference: ~x is MASK-x, the add is plain integer arithmetic, and overflow
  // is the exact signed sum falling outside the W-bit two's-complement range.
  function automatic exp_t model(input logic [2:0] op, input int a, input int b,
                                 input int acc, input int cf);
    int am, bm, ci, tot, st;
    exp_t e;
    am = 0; bm = a; ci = 0;
    case (op)
      3'd0: begin am = 0;   bm = a;        ci = 0;  end
      3'd1: begin am = 0;   bm = MASK - a; ci = 1;  end
      3'd2: begin am = a;   bm = b;        ci = 0;  end
      3'd3: begin am = a;   bm = 0;        ci = 1;  end
      3'd4: begin am = a;   bm = MASK - b; ci = 1;  end
      3'd5: begin am = acc; bm = a;        ci = 0;  end
      3'd6: begin am = acc; bm = MASK - a; ci = 1;  end
      default: begin am = a; bm = b;       ci = cf; end
    endcase
    tot = am + bm + ci;
    st  = to_signed(am) + to_signed(bm) + ci;
    e.r = W'(tot % MOD);
    e.c = (tot >= MOD);
    e.z = ((tot % MOD) == 0);
    e.n = ((tot % MOD) >= HALF);
    e.v = (st > HALF - 1) || (st < -HALF);
    return e;
  endfunction

  // Compare process: outputs and handshakes are sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      m_acc <= 0;
      m_cf  <= 0;
    end else begin
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", bus.out_valid, 0);
        end else begin
          check("model_R", bus.R, exp_q[0].r);
          check("model_ZCNV", {bus.Z, bus.C, bus.N, bus.V},
                {exp_q[0].z, exp_q[0].c, exp_q[0].n, exp_q[0].v});
          if (bus.out_ready) void'(exp_q.pop_front());
        end
        if (bus.out_ready) begin
          seen_r.push_back(int'(bus.R));
          seen_c.push_back(int'(bus.C));
          seen_cyc.push_back(cyc);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.Op, int'(bus.A), int'(bus.B), m_acc, m_cf));
        m_acc <= int'(exp_q[$].r);
        m_cf  <= int'(exp_q[$].c);
      end
    end
  end

  task automatic clear_seen();
    seen_r.delete();
    seen_c.delete();
    seen_cyc.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input int a, input int b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.Op       = op;
    bus.A        = W'(a);
    bus.B        = W'(b);
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 100) begin
        check("issue_timeout_in_ready", bus.in_ready, 1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [2:0] op, input int a, input int b,
                         input int er, input logic [3:0] ezcnv);
    issue(op, a, b);
    check({name, "_valid_after_accept"}, bus.out_valid, 0);
    @(posedge clk); #1;
    check({name, "_valid_next_edge"}, bus.out_valid, 1);
    check({name, "_R"}, bus.R, er);
    check({name, "_ZCNV"}, {bus.Z, bus.C, bus.N, bus.V}, ezcnv);
    @(posedge clk); #1;
    check({name, "_valid_drop"}, bus.out_valid, 0);
  endtask

  task automatic do_reset(input string name);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check({name, "_out_valid"}, bus.out_valid, 0);
    check({name, "_R"}, bus.R, 0);
    check({name, "_ZCNV"}, {bus.Z, bus.C, bus.N, bus.V}, 4'b0000);
    check({name, "_in_ready"}, bus.in_ready, 1);
    @(negedge clk);
    @(posedge clk); #3;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Op        = 3'b000;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_R", bus.R, 0);
    check("reset_ZCNV", {bus.Z, bus.C, bus.N, bus.V}, 4'b0000);
    #2;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single ops with literal expectations, {Z,C,N,V}.
    run_one("add_7_9",  3'b010, 7, 9, 0,    4'b1100);
    run_one("sub_3_5",  3'b100, 3, 5, 'hE,  4'b0010);
    run_one("neg_8",    3'b001, 8, 0, 8,    4'b0011);
    run_one("inc_F",    3'b011, 'hF, 0, 0,  4'b1100);
    run_one("xfer_6",   3'b000, 6, 0, 6,    4'b0000);

    // Back-to-back accumulator chain at full throughput.
    clear_seen();
    issue(3'b000, 5, 0);
    issue(3'b101, 6, 0);
    issue(3'b110, 2, 0);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_count", seen_r.size(), 3);
    if (seen_r.size() == 3) begin
      check("b2b_r0", seen_r[0], 5);
      check("b2b_r1", seen_r[1], 'hB);
      check("b2b_r2", seen_r[2], 9);
      check("b2b_gap01", seen_cyc[1] - seen_cyc[0], 1);
      check("b2b_gap12", seen_cyc[2] - seen_cyc[1], 1);
    end

    // Multiword add through the carry flag.
    clear_seen();
    issue(3'b010, 'hF, 1);
    issue(3'b111, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("mw_count", seen_r.size(), 2);
    if (seen_r.size() == 2) begin
      check("mw_r0", seen_r[0], 0);
      check("mw_c0", seen_c[0], 1);
      check("mw_r1", seen_r[1], 1);
      check("mw_c1", seen_c[1], 0);
    end

    // Backpressure: two ops fill the pipe, the third must wait.
    clear_seen();
    bus.out_ready = 1'b0;
    issue(3'b010, 1, 2);
    issue(3'b100, 9, 4);
    bus.in_valid = 1'b1;
    bus.Op       = 3'b011;
    bus.A        = W'(6);
    bus.B        = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", bus.in_ready, 0);
      check("bp_out_valid_held", bus.out_valid, 1);
      check("bp_R_stable", bus.R, 3);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_release", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_count", seen_r.size(), 3);
    if (seen_r.size() == 3) begin
      check("bp_r0", seen_r[0], 3);
      check("bp_r1", seen_r[1], 5);
      check("bp_r2", seen_r[2], 7);
    end

    // Reset mid-stream with ops in both stages; ACC must restart from 0.
    run_one("pre_rst", 3'b010, 'hE, 3, 1, 4'b0100);
    bus.out_ready = 1'b0;
    issue(3'b000, 6, 0);
    issue(3'b101, 4, 0);
    do_reset("rst1");
    run_one("acc_after_rst", 3'b101, 3, 0, 3, 4'b0000);

    // Reset must also clear CF.
    run_one("cf_set", 3'b010, 'hF, 1, 0, 4'b1100);
    do_reset("rst2");
    run_one("adc_after_rst", 3'b111, 5, 2, 7, 4'b0000);

    repeat (5) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
